inv_sub_bytes_ecc_decoder: RTL and testbench
============================================

// Module: inv_sub_bytes_ecc_decoder
// PURPOSE
//  Receive-side partner of the SubBytes Hamming predictor/checker: accepts 12-bit protected words
//  {sbox_byte[7:0], w[3:0]}, computes the syndrome, corrects single-bit errors, and flags uncorrectable ones.
//  Two-stage valid/ready pipeline; optionally maps the corrected byte back through the inverse S-box.
//  Sits between the fault-protected S-box datapath and downstream consumers/fault-logging.
// PARAMETERS
//  CNT_W  16  width of each saturating error-event counter
// PORTS
//  clk                 in   1      clock
//  rst_n               in   1      asynchronous, active-low reset
//  in_valid            in   1      input word valid
//  in_ready            out  1      decoder can accept (combinational from out_ready)
//  in_code             in   12     [11:4]=S-box byte, [3:0]=w[3:0]
//  out_valid           out  1      output valid
//  out_ready           in   1      downstream accepts
//  out_data            out  8      corrected byte (inverse-mapped when ECC_INV_SBOX_EN defined)
//  out_syndrome        out  4      syndrome {S3,S2,S1,S0} of the received word
//  out_corrected       out  1      single-bit error corrected (data or parity bit)
//  out_uncorrectable   out  1      syndrome matches no column; out_data is the uncorrected byte
//  cnt_clear           in   1      synchronous clear of both counters
//  cnt_corrected       out  CNT_W  count of corrected words delivered
//  cnt_uncorrectable   out  CNT_W  count of uncorrectable words delivered
// BEHAVIOUR
//  - Clock is clk; reset is asynchronous, active-low (rst_n). All regs -> 0 on reset: out_valid=0,
//    out_data=0, flags=0, out_syndrome=0, counters=0. Reset mid-operation discards in-flight words.
//  - Syndrome: S0=c11^c10^c8^c7^c6^c3; S1=c11^c10^c9^c8^c6^c4^c2; S2=c11^c10^c9^c7^c5^c4^c1;
//    S3=c11^c9^c8^c7^c5^c0.
//  - Columns {S3..S0}: c11=F c10=7 c9=E c8=B c7=D c6=3 c5=C c4=6 c3=1 c2=2 c1=4 c0=8.
//    Syndrome 0 -> clean. Syndrome equal to a column -> flip that bit, out_corrected=1.
//    Syndromes 5, 9, A -> out_uncorrectable=1, no flip. Flags mutually exclusive.
//  - Double errors whose syndrome aliases a column are mis-corrected (reported as corrected);
//    this is a property of the code, not a defect.
//  - Pipeline: stage 1 registers code+syndrome; stage 2 registers corrected/mapped byte+flags.
//    Latency is 2 cycles from in_valid&&in_ready to out_valid, with no bubbles at full throughput.
//  - Handshake: advance = !out_valid || out_ready; in_ready = advance. The whole pipe freezes on a stall.
//    out_* hold stable while out_valid && !out_ready. Empty stages carry valid=0 (bubbles propagate).
//  - Counters increment on out_valid&&out_ready per flag and saturate at all-ones (no wrap).
//    cnt_clear has priority over a same-cycle increment (result 0).
// CONFIGURATION
//  ECC_INV_SBOX_EN defined: stage 2 passes the corrected byte through the AES inverse S-box.
//    out_data is the original SubBytes input. On uncorrectable words, the raw byte is inverse-mapped.
//  ECC_INV_SBOX_EN undefined: out_data is the corrected S-box byte and no inverse table is built.
//    Latency, flags, and counters are identical.
// STRUCTURE
//  - Package ecc_sbox_pkg holds:
//    - CODE_W=12, DATA_W=8, SYN_W=4;
//    - H-matrix column constants (array of 12 x 4-bit);
//    - uncorrectable syndrome set {5,9,A};
//    - typedef code_t/syn_t.
//  - Sub-module inv_sub_bytes: combinational 256-entry inverse S-box, instantiated only under
//    ECC_INV_SBOX_EN.
// TESTING
//  1. Clean: in_code=0x63C (SubBytes(00)=63, w=C).
//     -> out_syndrome=0, no flags.
//     -> out_data=0x00 (ECC_INV_SBOX_EN) / 0x63 (undefined), exactly 2 cycles later.
//  2. Single data error: in_code=0xE3C (bit 11 flipped).
//     -> syndrome=F, out_corrected=1, out_data=0x00 / 0x63, cnt_corrected=1.
//  3. Single parity error: in_code=0x63D (bit 0 flipped).
//     -> syndrome=8, out_corrected=1, data unchanged.
//  4. Detectable double: in_code=0x636 (bits 3 and 1 flipped).
//     -> syndrome=5, out_uncorrectable=1, cnt_uncorrectable=1.
//  5. Backpressure: stream 4 words, hold out_ready=0 for 3 cycles.
//     -> in_ready=0 while stalled, out_* stable, no loss/duplication, order preserved.
//  6. Counters: force CNT_W=2, deliver 5 corrected words -> cnt_corrected=3.
//     Assert cnt_clear with a delivery in the same cycle -> 0. Assert rst_n low mid-stream -> all outputs 0.
//     Exhaustive: all 256 inputs x 12 single flips -> recovered byte correct.

Source files
------------

// File: rtl/ecc_sbox_pkg.sv
// rtl/ecc_sbox_pkg.sv - code geometry, H-matrix columns and syndrome helpers for the SubBytes ECC decoder
package ecc_sbox_pkg;
  localparam int CODE_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [SYN_W-1:0]  syn_t;

  // Indexed by code bit; the w[3:0] columns are unit vectors so each parity bit checks itself.
  localparam syn_t H_COL [CODE_W] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h6, 4'hC,
                                      4'h3, 4'hD, 4'hB, 4'hE, 4'h7, 4'hF};
  localparam syn_t UNCORR_SYN [3] = '{4'h5, 4'h9, 4'hA};

  function automatic syn_t calc_syndrome(input code_t code);
    syn_t s;
    s = '0;
    for (int i = 0; i < CODE_W; i++)
      if (code[i]) s = s ^ H_COL[i];
    return s;
  endfunction

  function automatic logic is_uncorrectable(input syn_t s);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++)
      if (s == UNCORR_SYN[i]) hit = 1'b1;
    return hit;
  endfunction
endpackage

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - combinational AES inverse S-box lookup
module inv_sub_bytes
  import ecc_sbox_pkg::*;
(
  input  logic [DATA_W-1:0] sbox_byte,
  output logic [DATA_W-1:0] plain_byte
);
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign plain_byte = INV_SBOX[sbox_byte];
endmodule

// File: rtl/inv_sub_bytes_ecc_decoder.sv
// rtl/inv_sub_bytes_ecc_decoder.sv - two-stage SEC Hamming decoder for protected S-box bytes; ECC_INV_SBOX_EN adds inverse S-box mapping
module inv_sub_bytes_ecc_decoder
  import ecc_sbox_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable
);
  logic              advance;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_byte;
  syn_t              s1_syn;
  code_t             flip_mask;
  logic [DATA_W-1:0] fixed_byte;
  logic [DATA_W-1:0] s2_byte;
  logic              s2_corr;
  logic              s2_unc;
  logic              deliver;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign deliver  = out_valid && out_ready;

  // Parity bits only feed the syndrome, so stage 1 keeps just the data byte alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_byte  <= '0;
      s1_syn   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_byte  <= in_code[CODE_W-1 -: DATA_W];
      s1_syn   <= calc_syndrome(in_code);
    end
  end

  // Columns are distinct and nonzero, so at most one bit is flipped and syndrome 0 flips none.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < CODE_W; i++)
      if (s1_syn == H_COL[i]) flip_mask[i] = 1'b1;
  end

  assign fixed_byte = s1_byte ^ flip_mask[CODE_W-1 -: DATA_W];
  assign s2_corr    = s1_valid && (|flip_mask);
  assign s2_unc     = s1_valid && is_uncorrectable(s1_syn);

`ifdef ECC_INV_SBOX_EN
  inv_sub_bytes u_inv_sub_bytes (
    .sbox_byte  (fixed_byte),
    .plain_byte (s2_byte)
  );
`else
  assign s2_byte = fixed_byte;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (advance) begin
      out_valid         <= s1_valid;
      out_data          <= s2_byte;
      out_syndrome      <= s1_syn;
      out_corrected     <= s2_corr;
      out_uncorrectable <= s2_unc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (cnt_clear) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (deliver) begin
      if (out_corrected && (cnt_corrected != '1))
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (out_uncorrectable && (cnt_uncorrectable != '1))
        cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_ecc_decoder.sv
// tb/tb_inv_sub_bytes_ecc_decoder.sv - table-driven and randomized bench for inv_sub_bytes_ecc_decoder (follows ECC_INV_SBOX_EN)
module tb_inv_sub_bytes_ecc_decoder;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [11:0]   in_code;
  logic [7:0]    out_data;
  logic [3:0]    out_syndrome;
  logic          out_corrected, out_uncorrectable, cnt_clear;
  logic [CW-1:0] cnt_corrected, cnt_uncorrectable;

  always #5 clk = ~clk;

  inv_sub_bytes_ecc_decoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable), .cnt_clear(cnt_clear),
    .cnt_corrected(cnt_corrected), .cnt_uncorrectable(cnt_uncorrectable)
  );

  typedef struct { logic [7:0] data; logic [3:0] syn; logic corr; logic unc; } exp_t;
  typedef struct { logic [11:0] code; logic [7:0] raw; logic [3:0] syn; logic corr; logic unc; } vec_t;

  exp_t exp_q[$];
  exp_t snap;
  vec_t tbl [8];
  int   n_vec = 0;
  int   n_fail = 0;
  int   mc_corr, mc_unc;
  logic stalled;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

`ifdef ECC_INV_SBOX_EN
  logic [7:0] inv_tbl [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = '0;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
`endif

  function automatic logic [7:0] map_exp(input logic [7:0] b);
`ifdef ECC_INV_SBOX_EN
    return inv_tbl[b];
`else
    return b;
`endif
  endfunction

  function automatic logic [3:0] syn_of(input logic [11:0] c);
    logic [3:0] s;
    s[0] = c[11] ^ c[10] ^ c[8] ^ c[7] ^ c[6] ^ c[3];
    s[1] = c[11] ^ c[10] ^ c[9] ^ c[8] ^ c[6] ^ c[4] ^ c[2];
    s[2] = c[11] ^ c[10] ^ c[9] ^ c[7] ^ c[5] ^ c[4] ^ c[1];
    s[3] = c[11] ^ c[9] ^ c[8] ^ c[7] ^ c[5] ^ c[0];
    return s;
  endfunction

  // Decode by searching for the single flip that yields a valid codeword.
  function automatic exp_t model(input logic [11:0] c);
    exp_t e;
    logic [11:0] fixed;
    fixed  = c;
    e.syn  = syn_of(c);
    e.corr = 1'b0;
    e.unc  = 1'b0;
    if (e.syn != 4'h0) begin
      for (int i = 0; i < 12; i++)
        if (syn_of(c ^ (12'd1 << i)) == 4'h0) begin
          fixed  = c ^ (12'd1 << i);
          e.corr = 1'b1;
        end
      e.unc = !e.corr;
    end
    e.data = map_exp(fixed[11:4]);
    return e;
  endfunction

  function automatic logic [11:0] encode(input logic [7:0] b);
    logic [3:0] s;
    s = syn_of({b, 4'h0});
    return {b, s[0], s[1], s[2], s[3]};
  endfunction

  task automatic cyc();
    exp_t e;
    #1;
    chk("in_ready_rule", in_ready, 32'(!out_valid || out_ready));
    if (in_valid && in_ready) exp_q.push_back(model(in_code));
    stalled = out_valid && !out_ready;
    snap = '{out_data, out_syndrome, out_corrected, out_uncorrectable};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_syndrome", out_syndrome, e.syn);
        chk("out_corrected", out_corrected, e.corr);
        chk("out_uncorrectable", out_uncorrectable, e.unc);
        if (e.corr && mc_corr < SAT) mc_corr++;
        if (e.unc && mc_unc < SAT) mc_unc++;
      end
    end
    if (cnt_clear) begin mc_corr = 0; mc_unc = 0; end
    @(posedge clk);
    #1;
    chk("cnt_corrected", cnt_corrected, mc_corr);
    chk("cnt_uncorrectable", cnt_uncorrectable, mc_unc);
    if (stalled) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, snap.data);
      chk("stall_syndrome", out_syndrome, snap.syn);
      chk("stall_flags", {out_corrected, out_uncorrectable}, {snap.corr, snap.unc});
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
`ifdef ECC_INV_SBOX_EN
    for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);
`endif
    tbl = '{'{12'h63C, 8'h63, 4'h0, 1'b0, 1'b0},
            '{12'hE3C, 8'h63, 4'hF, 1'b1, 1'b0},
            '{12'h63D, 8'h63, 4'h8, 1'b1, 1'b0},
            '{12'h636, 8'h63, 4'h5, 1'b0, 1'b1},
            '{12'h62C, 8'h63, 4'h6, 1'b1, 1'b0},
            '{12'h635, 8'h63, 4'h9, 1'b0, 1'b1},
            '{12'h639, 8'h63, 4'hA, 1'b0, 1'b1},
            '{12'hA3C, 8'hA3, 4'h8, 1'b1, 1'b0}};
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; cnt_clear = 1'b0;
    mc_corr = 0; mc_unc = 0; stalled = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_syndrome", out_syndrome, 0);
    chk("rst_flags", {out_corrected, out_uncorrectable}, 0);
    chk("rst_counters", {cnt_corrected, cnt_uncorrectable}, 0);
    rst_n = 1'b1;

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_code  = tbl[i].code;
      cyc();
      in_valid = 1'b0;
      chk("lat_not_early", out_valid, 0);
      cyc();
      chk("lat_valid", out_valid, 1);
      chk("tbl_data", out_data, map_exp(tbl[i].raw));
      chk("tbl_syndrome", out_syndrome, tbl[i].syn);
      chk("tbl_corrected", out_corrected, tbl[i].corr);
      chk("tbl_uncorrectable", out_uncorrectable, tbl[i].unc);
    end
    drain();

    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    in_valid = 1'b1;
    in_code  = 12'hE3C;
    repeat (5) cyc();
    drain();
    chk("sat_cnt_corrected", cnt_corrected, SAT);
    in_valid = 1'b1;
    in_code  = 12'hE3C;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("clear_deliver_valid", out_valid, 1);
    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    chk("clear_priority", cnt_corrected, 0);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 12'($urandom);
    cyc();
    in_code   = 12'($urandom);
    cyc();
    out_ready = 1'b0;
    in_code   = 12'($urandom);
    repeat (3) begin
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    in_code = 12'($urandom);
    cyc();
    drain();

    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int b = 0; b < 256; b++)
      for (int i = 0; i <= 12; i++) begin
        in_code = encode(8'(b)) ^ ((i < 12) ? (12'd1 << i) : 12'd0);
        cyc();
      end
    drain();

    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom % 4) != 0;
      in_code   = 12'($urandom);
      out_ready = ($urandom % 3) != 0;
      cnt_clear = ($urandom % 50) == 0;
      cyc();
      if (n == 1000) begin
        cnt_clear = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_syndrome", out_syndrome, 0);
        chk("midrst_flags", {out_corrected, out_uncorrectable}, 0);
        chk("midrst_counters", {cnt_corrected, cnt_uncorrectable}, 0);
        exp_q.delete();
        mc_corr = 0;
        mc_unc  = 0;
        stalled = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end
    cnt_clear = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
